// File: rtl/div_seq_if.sv
// EX-stage <-> divider bundle. EX drives the operands and the start/annul controls.
// The divider returns {HI,LO}, a ready flag and the stall request.
interface div_seq_if #(
    parameter int DATA_W = 32
) ();
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// stalls the pipeline until {remainder, quotient} is ready; a flush aborts it.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quot_q, quot_d;
    logic [DATA_W-1:0]     dvsr_q, dvsr_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic [DATA_W:0]       shifted_s;
    logic [DATA_W:0]       diff_s;
    logic                  borrow_s;
    logic [DATA_W-1:0]     rem_next_s;
    logic [DATA_W-1:0]     quot_next_s;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic en);
        if (en && v[DATA_W-1]) begin
            abs_val = {DATA_W{1'b0}} - v;
        end else begin
            abs_val = v;
        end
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic en);
        if (en) begin
            cond_neg = {DATA_W{1'b0}} - v;
        end else begin
            cond_neg = v;
        end
    endfunction

    // One restoring step; the MSB of the (DATA_W+1)-bit difference is the borrow.
    always_comb begin
        shifted_s   = {rem_q, quot_q[DATA_W-1]};
        diff_s      = shifted_s - {1'b0, dvsr_q};
        borrow_s    = diff_s[DATA_W];
        rem_next_s  = borrow_s ? shifted_s[DATA_W-1:0] : diff_s[DATA_W-1:0];
        quot_next_s = {quot_q[DATA_W-2:0], ~borrow_s};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            ST_IDLE: begin
                ready_d  = 1'b0;
                result_d = {(2*DATA_W){1'b0}};
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == {DATA_W{1'b0}}) begin
                        state_d = ST_BYZERO;
                    end else begin
                        quot_d     = abs_val(bus.opdata1_i, bus.signed_div_i);
                        dvsr_d     = abs_val(bus.opdata2_i, bus.signed_div_i);
                        neg_quot_d = bus.signed_div_i &
                                     (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                        neg_rem_d  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                        rem_d      = {DATA_W{1'b0}};
                        cnt_d      = {CNT_W{1'b0}};
                        state_d    = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BYZERO: begin
                if (bus.annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_DONE;
                    ready_d  = 1'b1;
                    result_d = {(2*DATA_W){1'b0}};
                end
            end
            ST_RUN: begin
                // A flush wins even over the final iteration.
                if (bus.annul_i) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    result_d = {(2*DATA_W){1'b0}};
                end else begin
                    rem_d  = rem_next_s;
                    quot_d = quot_next_s;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        ready_d  = 1'b1;
                        result_d = {cond_neg(rem_next_s, neg_rem_q),
                                    cond_neg(quot_next_s, neg_quot_q)};
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                if (bus.annul_i || !bus.start_i) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    result_d = {(2*DATA_W){1'b0}};
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ready_d  = 1'b0;
                result_d = {(2*DATA_W){1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            rem_q      <= {DATA_W{1'b0}};
            quot_q     <= {DATA_W{1'b0}};
            dvsr_q     <= {DATA_W{1'b0}};
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= {(2*DATA_W){1'b0}};
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.stallreq_o = bus.start_i & ~ready_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotient/remainder pairs, latency,
// divide-by-zero, annul, mid-divide reset and result hold while start stays high.
module tb_div_seq;
    localparam int DATA_W = 32;
    localparam int RUN_EDGES = DATA_W + 1;   // accept edge plus DATA_W iterations
    localparam int BYZ_EDGES = 2;            // accept edge plus the BYZERO edge

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    div_seq_if #(.DATA_W(DATA_W)) bus ();

    div_seq #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise start with operands, scramble operands after accept, wait (bounded) for ready.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_edges, input logic [63:0] exp_res);
        int edges;
        int stall_bad;
        edges = 0;
        stall_bad = 0;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        #1;
        while (!bus.ready_o && edges < 100) begin
            if (bus.stallreq_o !== 1'b1) stall_bad++;
            @(negedge clk);
            edges++;
            if (edges == 1) begin
                bus.signed_div_i = ~sgn;
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
            end
        end
        check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        check({tag, "_result"}, bus.result_o, exp_res);
        check({tag, "_stall_while_busy"}, 64'(stall_bad), 64'd0);
        check({tag, "_stall_at_ready"}, {63'd0, bus.stallreq_o}, 64'd0);
    endtask

    // Drop start; divider must return to idle with ready and result cleared.
    task automatic release_div(input string tag);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, {63'd0, bus.ready_o}, 64'd0);
        check({tag, "_idle_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        int saw_ready;
        logic [63:0] held;

        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd0;
        bus.opdata2_i = 32'd0;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        check("reset_stall", {63'd0, bus.stallreq_o}, 64'd0);
        rst = 1'b0;

        // Test 1: DIVU 100/7
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, RUN_EDGES, {32'd2, 32'd14});
        release_div("divu_100_7");

        // Test 2: signed sign correction, plus the same bits unsigned
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, RUN_EDGES, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        release_div("div_m7_2");
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, RUN_EDGES, {32'h0000_0001, 32'hFFFF_FFFD});
        release_div("div_7_m2");
        run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, RUN_EDGES,
                {32'hFFFF_FFFE, 32'd14});
        release_div("div_m100_m7");
        run_div("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, RUN_EDGES, {32'd1, 32'h7FFF_FFFC});
        release_div("divu_fff9_2");

        // Test 3: divide by zero
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, BYZ_EDGES, 64'd0);
        check("divu_5_0_ready", {63'd0, bus.ready_o}, 64'd1);
        release_div("divu_5_0");

        // Test 4: annul at RUN cycle 10, then a fresh 9/3
        saw_ready = 0;
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'hFFFF_FFFF;
        bus.opdata2_i = 32'd3;
        bus.start_i = 1'b1;
        repeat (11) begin
            @(negedge clk);
            if (bus.ready_o) saw_ready++;
        end
        bus.annul_i = 1'b1;
        @(negedge clk);
        check("annul_ready", {63'd0, bus.ready_o}, 64'd0);
        check("annul_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) saw_ready++;
        end
        check("annul_never_ready", 64'(saw_ready), 64'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, RUN_EDGES, {32'd0, 32'd3});
        release_div("divu_9_3");

        // Test 5: MIN_INT/-1 wraps; unsigned max / 1; large unsigned divisor
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, RUN_EDGES, {32'd0, 32'h8000_0000});
        release_div("div_min_m1");
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, RUN_EDGES, {32'd0, 32'hFFFF_FFFF});
        release_div("divu_max_1");
        run_div("divu_max_maxm1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, RUN_EDGES, {32'd1, 32'd1});

        // Test 6b: hold start through DONE for 5 cycles, result stable
        held = bus.result_o;
        repeat (5) begin
            @(negedge clk);
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom | 32'd1;
            check("hold_ready", {63'd0, bus.ready_o}, 64'd1);
            check("hold_result", bus.result_o, {32'd1, 32'd1});
        end
        check("hold_stable", bus.result_o, held);
        release_div("divu_max_maxm1");

        // Test 6: synchronous reset at RUN cycle 20
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {63'd0, bus.ready_o}, 64'd0);
        check("rst_mid_result", bus.result_o, 64'd0);
        rst = 1'b0;
        run_div("divu_15_4_after_rst", 1'b0, 32'd15, 32'd4, RUN_EDGES, {32'd3, 32'd3});
        release_div("divu_15_4_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
